pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 160, SHALL set the payload width in bits (5 x 32-bit fields: IR, pc, pc4, ALUout, DMout).
REQ-002 Parameter SKID, default 1, SHALL select the buffering mode: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept the payload.
REQ-008 in_data  input  PAYLOAD_W  upstream payload.
REQ-009 flush  input  1  synchronous discard of all held entries.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts the payload.
REQ-012 out_data  output  PAYLOAD_W  head-entry payload; all zeros (NOP bubble) whenever out_valid=0.
REQ-013 occupancy  output  2  number of held entries (0..2).
REQ-014 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 in_fire = in_valid & in_ready, and out_fire = out_valid & out_ready; a transfer occurs only on a fire.
REQ-016 SKID=1: the FSM SHALL have states EMPTY, ONE and TWO, with out_valid = (state != EMPTY) and in_ready = (state != TWO), both registered.
REQ-017 EMPTY: on in_fire, main <= in_data and the FSM goes to ONE; otherwise it stays in EMPTY.
REQ-018 ONE transitions:
- in_fire only: skid <= in_data, go to TWO.
- out_fire only: go to EMPTY.
- both: main <= in_data, stay in ONE.
- neither: hold.
REQ-019 TWO: on out_fire, main <= skid and the FSM goes to ONE; otherwise it holds with in_ready=0.
REQ-020 SKID=0: only EMPTY and ONE SHALL exist, with in_ready = !out_valid | out_ready (combinational), and the payload passes through in 1 cycle when out_fire and in_fire coincide.
REQ-021 Latency from in_fire in EMPTY to out_valid=1 SHALL be exactly 1 cycle; order SHALL be strictly FIFO, with no loss or duplication.
REQ-022 flush=1 SHALL force the EMPTY state at the next edge, with highest priority over any same-cycle in_fire and out_fire; the input accepted in that cycle is discarded.
REQ-023 While out_valid=0, out_data SHALL equal 0; the main and skid registers are not required to be cleared.
REQ-024 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-025 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.

Reset
REQ-026 reset=0 SHALL asynchronously force the following, independent of clk:
- state EMPTY;
- out_valid=0, out_data=0, occupancy=0, stall_cnt=0;
- main=0, skid=0;
- in_ready=1 (SKID=1) or in_ready=1 via its combinational equation (SKID=0).
REQ-027 Reset asserted mid-transfer SHALL drop all held entries; the first in_fire after deassertion is accepted normally.
REQ-028 Reset deassertion SHALL take effect at the next rising clk edge; no fire is recognised in the deassertion cycle if reset is still low at that edge.

Structure
REQ-029 Shared package pipe_pkg SHALL hold:
- the state enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
- NOP_WORD=32'h0000_0000;
- the field offsets of IR, pc, pc4, ALUout and DMout within the payload.
REQ-030 The saturating counter SHALL be the sub-module pipe_sat_counter (parameter CNT_W; ports clk, reset, inc, count).
REQ-031 The SKID mode SHALL be selected by generate; there SHALL be no runtime mode input.

Verification
REQ-032 Passthrough: out_ready=1, SKID=1, push payloads 1,2,3 on consecutive cycles -> out_data = 1,2,3 on cycles +1..+3, occupancy never >1, stall_cnt=0.
REQ-033 Skid fill:
- stimulus: SKID=1, out_ready=0, push A=0xA, B=0xB;
- response: occupancy=2, in_ready=0, out_data=0xA;
- then: out_ready=1 for 2 cycles -> 0xA then 0xB, in_ready returns to 1.
REQ-034 Flush collision: state TWO and flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0; the input is dropped.
REQ-035 Stall saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt = 15 and holds; a flush leaves it at 15.
REQ-036 Async reset: assert reset=0 mid-cycle while in ONE -> out_valid=0 and stall_cnt=0 before the next clk edge.
REQ-037 SKID=0: out_ready=0 with an entry held -> in_ready=0; raise out_ready -> in_ready=1 in the same cycle, and the simultaneous in_fire/out_fire keeps occupancy=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and payload layout for the pipeline stage register.
package pipe_pkg;

    // Occupancy-encoded stage states: the enum value equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Bubble word presented downstream when no entry is valid.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Field layout of the 160-bit payload (LSB offsets, 32 bits each).
    localparam int FIELD_W    = 32;
    localparam int DMOUT_LSB  = 0;
    localparam int ALUOUT_LSB = 32;
    localparam int PC4_LSB    = 64;
    localparam int PC_LSB     = 96;
    localparam int IR_LSB     = 128;

    // Number of held entries for a given state.
    function automatic logic [1:0] occupancy_of(state_t s);
        return logic'(s != EMPTY) ? ((s == TWO) ? 2'd2 : 2'd1) : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Increment on request unless already saturated.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush, NOP bubble on empty output and a stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 160,
    parameter bit SKID      = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_out_valid;
    logic [PAYLOAD_W-1:0]   r_main;
    logic [PAYLOAD_W-1:0]   r_skid;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load_main;
    logic                   w_main_from_skid;
    logic                   w_load_skid;
    logic                   w_stall;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic r_in_ready;

            // Next state and register loads for the two-entry skid buffer.
            always_comb begin
                // NOTE: every combinational output gets a default first so no path infers a latch.
                w_state_nxt      = r_state;
                w_load_main      = 1'b0;
                w_main_from_skid = 1'b0;
                w_load_skid      = 1'b0;
                if (flush) begin
                    w_state_nxt = EMPTY;
                end else begin
                    unique case (r_state)
                        EMPTY: begin
                            if (w_in_fire) begin
                                w_load_main = 1'b1;
                                w_state_nxt = ONE;
                            end
                        end
                        ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                w_load_main = 1'b1;
                            end else if (w_in_fire) begin
                                w_load_skid = 1'b1;
                                w_state_nxt = TWO;
                            end else if (w_out_fire) begin
                                w_state_nxt = EMPTY;
                            end
                        end
                        TWO: begin
                            if (w_out_fire) begin
                                w_load_main      = 1'b1;
                                w_main_from_skid = 1'b1;
                                w_state_nxt      = ONE;
                            end
                        end
                        default: w_state_nxt = EMPTY;
                    endcase
                end
            end

            // Registered in_ready: low only while both entries are held.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != TWO);
                end
            end

            assign in_ready = r_in_ready;
        end else begin : g_single
            // Next state and register loads for the single-entry stage.
            always_comb begin
                w_state_nxt      = r_state;
                w_load_main      = 1'b0;
                w_main_from_skid = 1'b0;
                w_load_skid      = 1'b0;
                if (flush) begin
                    w_state_nxt = EMPTY;
                end else begin
                    unique case (r_state)
                        EMPTY: begin
                            if (w_in_fire) begin
                                w_load_main = 1'b1;
                                w_state_nxt = ONE;
                            end
                        end
                        ONE: begin
                            if (w_out_fire && w_in_fire) begin
                                w_load_main = 1'b1;
                            end else if (w_out_fire) begin
                                w_state_nxt = EMPTY;
                            end
                        end
                        default: w_state_nxt = EMPTY;
                    endcase
                end
            end

            // Accept when empty or when the held entry leaves this cycle.
            assign in_ready = !r_out_valid | out_ready;
        end
    endgenerate

    // State register with a registered copy of out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    // Payload registers: main is the head entry, skid holds the second.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the payload registers are reset to zero because the stage must come out of reset fully cleared.
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_main : {(PAYLOAD_W){NOP_WORD[0]}};
    assign occupancy = occupancy_of(r_state);
    assign w_stall   = r_out_valid & ~out_ready;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cnt)
    );

endmodule
